// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester side and the transmitter side of the UART TX
//   arbiter into one interface.
//
//   Parameters
//     NREQ : number of byte requesters (2..8)
//     DW   : data width per byte
//     GW   : grant index width, derived from NREQ
//
//   Signals
//     i_req_valid  [NREQ]     bit k: requester k presents a byte
//     i_req_data   [NREQ*DW]  requester k byte in bits [k*DW +: DW]
//     o_req_ready  [NREQ]     bit k: holding register k is empty
//     o_tx_start              one-cycle start pulse to the transmitter
//     o_tx_data    [DW]       byte for the transmitter, valid with o_tx_start
//     i_tx_busy               transmitter busy flag
//     o_grant      [GW]       index of the requester last granted
//     o_busy                  arbiter is not idle
//     o_timeout               one-cycle pulse on watchdog abort
//
//   Modports
//     master : the arbiter (drives the o_* signals)
//     slave  : the environment (requesters plus transmitter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic               o_tx_start;
  logic [DW-1:0]      o_tx_data;
  logic               i_tx_busy;
  logic [GW-1:0]      o_grant;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    input  i_req_valid,
    input  i_req_data,
    input  i_tx_busy,
    output o_req_ready,
    output o_tx_start,
    output o_tx_data,
    output o_grant,
    output o_busy,
    output o_timeout
  );

  modport slave (
    output i_req_valid,
    output i_req_data,
    output i_tx_busy,
    input  o_req_ready,
    input  o_tx_start,
    input  o_tx_data,
    input  o_grant,
    input  o_busy,
    input  o_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter between NREQ byte
//   sources. Each source owns a one-byte holding register; the arbiter picks a
//   pending byte, pulses start to the transmitter for one cycle and then waits
//   for the transmitter busy cycle (rise then fall) before arbitrating again.
//
//   Parameters
//     NREQ           : number of requesters, 2..8
//     DW             : data width per byte
//     TIMEOUT_CYCLES : cycles allowed in WAIT_BUSY before abort (timeout build)
//
//   Ports
//     clk     : system clock
//     i_reset : asynchronous, active-high reset
//     bus     : uart_tx_arbiter_if.master (requester and transmitter signals)
//
//   Build option
//     UART_ARB_TIMEOUT_EN : when defined, a watchdog aborts WAIT_BUSY after
//                           TIMEOUT_CYCLES cycles and pulses o_timeout. When
//                           undefined, WAIT_BUSY waits forever and o_timeout
//                           is tied low.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned DW             = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                i_reset,
  uart_tx_arbiter_if.master   bus
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] hold_valid_q, hold_valid_d;
  logic [DW-1:0]   hold_data_q [NREQ];
  logic [DW-1:0]   hold_data_d [NREQ];
  logic [GW-1:0]   grant_q, grant_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [NREQ-1:0] req_ready;
  logic            timeout;

  // Arbitration results
  logic            pick_found;
  logic [GW-1:0]   pick_idx;

  // Ready is forced low while reset is held so no byte is taken during reset.
  assign req_ready = ~hold_valid_q & {NREQ{~i_reset}};

  // -------------------------------------------------------------------------
  // Round-robin search: first pending index after the last grant, wrapping.
  // -------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] idx_w;
    pick_found = 1'b0;
    pick_idx   = grant_q;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx   = (32'(grant_q) + i) % NREQ;
      idx_w = GW'(idx);
      if (!pick_found && hold_valid_q[idx_w]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Holding registers: accept on valid&&ready, clear the granted slot in START.
  // Ready of the granted slot is low during START, so clear and accept never
  // collide on the same slot.
  // -------------------------------------------------------------------------
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (bus.i_req_valid[k] && req_ready[k]) begin
        hold_valid_d[k] = 1'b1;
        hold_data_d[k]  = bus.i_req_data[k*DW +: DW];
      end
    end
    if (state_q == StStart) begin
      hold_valid_d[grant_q] = 1'b0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // -------------------------------------------------------------------------
  // FSM next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    timeout   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          // Byte is latched here so o_tx_data is already valid during START.
          tx_data_d = hold_data_q[pick_idx];
          state_d   = StStart;
        end
      end
      StStart: begin
        state_d = StWaitBusy;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = CntW'(TIMEOUT_CYCLES - 1);
`endif
      end
      StWaitBusy: begin
        if (bus.i_tx_busy) begin
          state_d = StWaitDone;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          // Transmitter never responded; the byte is already dropped.
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
`endif
        end
      end
      StWaitDone: begin
        if (!bus.i_tx_busy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= StIdle;
      hold_valid_q <= '0;
      grant_q      <= GW'(NREQ - 1);
      tx_data_q    <= '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
        hold_data_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      hold_data_q  <= hold_data_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.o_req_ready = req_ready;
  assign bus.o_tx_start  = (state_q == StStart);
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_timeout   = timeout;

endmodule
